// File: rtl/morse_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : morse_pkg
//  Brief    : Shared constants and the Morse symbol -> ASCII lookup function.
//             Digit table entries are present only when MORSE_DIGITS_EN is
//             defined.
//  Revision : 1.0  initial release
// ============================================================================
package morse_pkg;

   localparam int         MORSE_MAX_LEN = 8;
   localparam logic [7:0] ASCII_NUL     = 8'h00;
   localparam logic [7:0] ASCII_QMARK   = 8'h3F;

   // Returns {err, char}. Elements are 0=dot, 1=dash, last element in the LSB,
   // so the first element sits at bit (len-1). Bits above len are masked off.
   function automatic logic [8:0] morse_lookup(input logic [3:0] len,
                                               input logic [7:0] code);
      logic [7:0] m;
      logic [7:0] c;
      m = (len >= 4'(MORSE_MAX_LEN)) ? code : (code & ~(8'hFF << len));
      c = ASCII_QMARK;
      case (len)
         4'd1: c = m[0] ? "T" : "E";
         4'd2:
            case (m[1:0])
               2'b00: c = "I";
               2'b01: c = "A";
               2'b10: c = "N";
               default: c = "M";
            endcase
         4'd3:
            case (m[2:0])
               3'b000: c = "S";
               3'b001: c = "U";
               3'b010: c = "R";
               3'b011: c = "W";
               3'b100: c = "D";
               3'b101: c = "K";
               3'b110: c = "G";
               default: c = "O";
            endcase
         4'd4:
            case (m[3:0])
               4'b0000: c = "H";
               4'b0001: c = "V";
               4'b0010: c = "F";
               4'b0100: c = "L";
               4'b0110: c = "P";
               4'b0111: c = "J";
               4'b1000: c = "B";
               4'b1001: c = "X";
               4'b1010: c = "C";
               4'b1011: c = "Y";
               4'b1100: c = "Z";
               4'b1101: c = "Q";
               default: c = ASCII_QMARK;
            endcase
`ifdef MORSE_DIGITS_EN
         4'd5:
            case (m[4:0])
               5'b11111: c = "0";
               5'b01111: c = "1";
               5'b00111: c = "2";
               5'b00011: c = "3";
               5'b00001: c = "4";
               5'b00000: c = "5";
               5'b10000: c = "6";
               5'b11000: c = "7";
               5'b11100: c = "8";
               5'b11110: c = "9";
               default:  c = ASCII_QMARK;
            endcase
`endif
         default: c = ASCII_QMARK;
      endcase
      // '?' is never a valid decode, so it doubles as the error marker
      return {(c == ASCII_QMARK), c};
   endfunction

endpackage
`default_nettype wire

// File: rtl/morse_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : morse_fifo
//  Brief    : Synchronous FIFO, combinational head read. A push while full is
//             accepted only when a pop happens in the same cycle.
//  Revision : 1.0  initial release
// ============================================================================
module morse_fifo #(
   parameter int WIDTH = 9,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];
   assign level   = count;

   // Storage array; no reset needed since reads are gated by occupancy
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   // Pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/morse_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : morse_decoder
//  Brief    : Decodes captured Morse symbols to ASCII, buffers them in a FIFO
//             and presents them on a valid/ready output. Two-clock latency.
//             Define MORSE_DIGITS_EN to decode 5-element digit codes.
//  Revision : 1.0  initial release
// ============================================================================
module morse_decoder
   import morse_pkg::*;
#(
   parameter int         DEPTH        = 8,
   parameter logic [7:0] UNKNOWN_CHAR = 8'h3F
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   input  logic [3:0]               in_length,
   input  logic [7:0]               in_code,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [7:0]               out_char,
   output logic                     out_err,
   output logic                     overflow,
   output logic [$clog2(DEPTH):0]   level
);
   logic [8:0] lookup;
   logic       d_valid;
   logic [8:0] d_data;
   logic [8:0] head;
   logic       full;
   logic       empty;
   logic       pop;

   assign lookup = morse_lookup(in_length, in_code);

   // Stage D: register the decoded {err, char}; unknown codes map to UNKNOWN_CHAR
   always_ff @(posedge clk) begin
      if (rst) begin
         d_valid <= 1'b0;
         d_data  <= '0;
      end else begin
         d_valid <= in_valid;
         d_data  <= {lookup[8], (lookup[8] ? UNKNOWN_CHAR : lookup[7:0])};
      end
   end

   assign pop = out_valid && out_ready;

   // Stage W: push decoded character; FIFO drops it when full without a pop
   morse_fifo #(
      .WIDTH (9),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (d_valid),
      .pop   (pop),
      .din   (d_data),
      .dout  (head),
      .full  (full),
      .empty (empty),
      .level (level)
   );

   // Sticky drop indicator, cleared only by reset
   always_ff @(posedge clk) begin
      if (rst)                            overflow <= 1'b0;
      else if (d_valid && full && !pop)   overflow <= 1'b1;
   end

   assign out_valid = !empty;
   assign out_char  = empty ? ASCII_NUL : head[7:0];
   assign out_err   = !empty && head[8];

endmodule
`default_nettype wire

// File: tb/tb_morse_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_morse_decoder
//  Brief    : Self-checking bench for morse_decoder with an expected-output
//             queue and an independent output monitor.
//  Revision : 1.0  initial release
// ============================================================================
module tb_morse_decoder;
   localparam int DEPTH = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic [3:0] in_length = '0;
   logic [7:0] in_code = '0;
   logic       out_ready = 1'b0;
   logic       out_valid;
   logic [7:0] out_char;
   logic       out_err;
   logic       overflow;
   logic [3:0] level;

   int errors = 0;
   int checks = 0;
   logic [8:0] sb [$];

   morse_decoder #(.DEPTH(DEPTH), .UNKNOWN_CHAR(8'h3F)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_length (in_length),
      .in_code   (in_code),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_char  (out_char),
      .out_err   (out_err),
      .overflow  (overflow),
      .level     (level)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Drivers act at posedge+1, so all inputs are stable across each negedge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [3:0] len, input logic [7:0] code,
                       input logic err, input logic [7:0] ch, input bit expect_out);
      in_valid  = 1'b1;
      in_length = len;
      in_code   = code;
      if (expect_out) sb.push_back({err, ch});
      step();
      in_valid  = 1'b0;
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      out_ready = 1'b1;
      while (level != 0 && n < 40) begin
         step();
         n++;
      end
      chk(name, {31'd0, (level == 0)}, 32'd1);
      step();
   endtask

   // Monitor: any accepted output must match the front of the expected queue
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_out: got char %0h err %0b expected none", out_char, out_err);
         end else begin
            if ({out_err, out_char} !== sb[0]) begin
               errors++;
               $display("FAIL out_data: got err=%0b char=%0h expected err=%0b char=%0h",
                        out_err, out_char, sb[0][8], sb[0][7:0]);
            end
            void'(sb.pop_front());
         end
      end
   end

   initial begin
      // 1: reset state and two-clock latency
      repeat (3) step();
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_char",  {24'd0, out_char},  32'd0);
      chk("rst_out_err",   {31'd0, out_err},   32'd0);
      chk("rst_overflow",  {31'd0, overflow},  32'd0);
      chk("rst_level",     {28'd0, level},     32'd0);
      rst = 1'b0;
      step();
      out_ready = 1'b0;
      send(4'd2, 8'b01, 1'b0, 8'h41, 1'b1);
      chk("lat_n1_valid", {31'd0, out_valid}, 32'd0);
      step();
      chk("lat_n2_valid", {31'd0, out_valid}, 32'd1);
      chk("lat_n2_char",  {24'd0, out_char},  32'h41);
      drain("t1_drain");

      // 2: buffer four letters, then stream them out one per cycle
      out_ready = 1'b0;
      send(4'd1, 8'b0,   1'b0, "E", 1'b1);
      send(4'd1, 8'b1,   1'b0, "T", 1'b1);
      send(4'd3, 8'b000, 1'b0, "S", 1'b1);
      send(4'd3, 8'b111, 1'b0, "O", 1'b1);
      step();
      step();
      chk("t2_level4", {28'd0, level}, 32'd4);
      chk("t2_head_stable", {24'd0, out_char}, 32'h45);
      out_ready = 1'b1;
      repeat (4) step();
      chk("t2_level0", {28'd0, level}, 32'd0);
      chk("t2_valid0", {31'd0, out_valid}, 32'd0);

      // 3: unknown codes, masking of bits above the length
      send(4'd0, 8'h5A,        1'b1, 8'h3F, 1'b1);
      send(4'd4, 8'b1111,      1'b1, 8'h3F, 1'b1);
      send(4'd7, 8'b0,         1'b1, 8'h3F, 1'b1);
      send(4'd2, 8'b111111_01, 1'b0, 8'h41, 1'b1);
      send(4'd4, 8'b1101,      1'b0, "Q",   1'b1);
      send(4'd15, 8'hFF,       1'b1, 8'h3F, 1'b1);
      drain("t3_drain");

      // 4: overflow on the ninth push, then push-while-full with a pop
      out_ready = 1'b0;
      send(4'd1, 8'b0,   1'b0, "E", 1'b1);
      send(4'd1, 8'b1,   1'b0, "T", 1'b1);
      send(4'd2, 8'b00,  1'b0, "I", 1'b1);
      send(4'd2, 8'b01,  1'b0, "A", 1'b1);
      send(4'd2, 8'b10,  1'b0, "N", 1'b1);
      send(4'd2, 8'b11,  1'b0, "M", 1'b1);
      send(4'd3, 8'b000, 1'b0, "S", 1'b1);
      send(4'd3, 8'b001, 1'b0, "U", 1'b1);
      send(4'd3, 8'b010, 1'b0, "R", 1'b0);
      step();
      step();
      chk("t4_level_full", {28'd0, level},    32'd8);
      chk("t4_overflow",   {31'd0, overflow}, 32'd1);
      send(4'd3, 8'b011, 1'b0, "W", 1'b1);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("t4_level_push_pop", {28'd0, level}, 32'd8);
      drain("t4_drain");
      chk("t4_overflow_sticky", {31'd0, overflow}, 32'd1);

      // 5: five-element digit code
`ifdef MORSE_DIGITS_EN
      send(4'd5, 8'b11111, 1'b0, "0", 1'b1);
      send(4'd5, 8'b11110, 1'b0, "9", 1'b1);
      send(4'd5, 8'b10101, 1'b1, 8'h3F, 1'b1);
`else
      send(4'd5, 8'b11111, 1'b1, 8'h3F, 1'b1);
      send(4'd5, 8'b00000, 1'b1, 8'h3F, 1'b1);
`endif
      drain("t5_drain");

      // 6: reset with five buffered and one in flight
      out_ready = 1'b0;
      send(4'd1, 8'b0,   1'b0, "E", 1'b0);
      send(4'd1, 8'b1,   1'b0, "T", 1'b0);
      send(4'd2, 8'b00,  1'b0, "I", 1'b0);
      send(4'd2, 8'b01,  1'b0, "A", 1'b0);
      send(4'd2, 8'b10,  1'b0, "N", 1'b0);
      send(4'd2, 8'b11,  1'b0, "M", 1'b0);
      chk("t6_level5", {28'd0, level}, 32'd5);
      rst = 1'b1;
      step();
      chk("t6_level0",    {28'd0, level},     32'd0);
      chk("t6_valid0",    {31'd0, out_valid}, 32'd0);
      chk("t6_overflow0", {31'd0, overflow},  32'd0);
      rst = 1'b0;
      out_ready = 1'b1;
      repeat (5) step();
      chk("t6_no_stale", {31'd0, out_valid}, 32'd0);

      chk("sb_empty", sb.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
